memory_page_ctrl: RTL

MEMORY_PAGE_CTRL -- requirements
Module: memory_page_ctrl

---
 rtl/memory_ctrl_pkg.sv | 15 +
 rtl/memory_page_ctrl_if.sv | 52 +++++
 rtl/rd_out_reg.sv | 27 ++
 rtl/memory_page_ctrl.sv | 95 +++++++++
 4 files changed

// File: rtl/memory_ctrl_pkg.sv
// Shared definitions for the memory page controller: burst FSM states and
// default element/address widths for an 8192-element page.
package memory_ctrl_pkg;

  localparam int unsigned ELEM_WIDTH_DEF = 8;
  localparam int unsigned ADDR_WIDTH_DEF = 13;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN
  } state_e;

endpackage

// File: rtl/memory_page_ctrl_if.sv
// Request, write-stream, read-stream and page-side signals of the page controller.
// slave = controller side, master = requester/page side.
interface memory_page_ctrl_if
  import memory_ctrl_pkg::*;
#(
  parameter int unsigned ELEM_WIDTH = ELEM_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) ();

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_write_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [ADDR_WIDTH-1:0] req_len_i;
  logic                  busy_o;
  logic                  done_o;

  logic                  wr_valid_i;
  logic                  wr_ready_o;
  logic [ELEM_WIDTH-1:0] wr_data_i;
  logic                  rd_valid_o;
  logic                  rd_ready_i;
  logic [ELEM_WIDTH-1:0] rd_data_o;

  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_we_o;
  logic [ELEM_WIDTH-1:0] mem_wdata_o;
  logic [ELEM_WIDTH-1:0] mem_rdata_i;

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_len_i,
    output req_ready_o, busy_o, done_o,
    input  wr_valid_i, wr_data_i,
    output wr_ready_o,
    output rd_valid_o, rd_data_o,
    input  rd_ready_i,
    output mem_addr_o, mem_we_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_len_i,
    input  req_ready_o, busy_o, done_o,
    output wr_valid_i, wr_data_i,
    input  wr_ready_o,
    input  rd_valid_o, rd_data_o,
    output rd_ready_i,
    input  mem_addr_o, mem_we_o, mem_wdata_o,
    output mem_rdata_i
  );

endinterface

// File: rtl/rd_out_reg.sv
// Single-entry valid/ready holding register for read beats; data stays
// stable while valid is high and the consumer is not ready.
module rd_out_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      data_o  <= data_i;
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/memory_page_ctrl.sv
// Burst controller for a single memory page: accepts read/write bursts and
// streams beats between the request side and a combinational-read page.
module memory_page_ctrl
  import memory_ctrl_pkg::*;
#(
  parameter int unsigned ELEM_WIDTH = ELEM_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                clk_i,
  input  logic                srst_i,
  memory_page_ctrl_if.slave   bus
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] beats_q;
  logic                  done_q, done_d;
  logic                  accept, wr_beat, rd_load, rd_pop, last_beat;
  logic                  rd_valid;
  logic [ELEM_WIDTH-1:0] rd_data;

  assign accept    = (state_q == IDLE) && bus.req_valid_i;
  assign wr_beat   = (state_q == WRITE) && bus.wr_valid_i;
  assign rd_pop    = rd_valid && bus.rd_ready_i;
  // Capture a new beat whenever the holding register is free this cycle.
  assign rd_load   = (state_q == READ) && (!rd_valid || bus.rd_ready_i);
  assign last_beat = (beats_q == '0);

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE:  if (accept) state_d = bus.req_write_i ? WRITE : READ;
      WRITE: if (wr_beat && last_beat) begin
               state_d = IDLE;
               done_d  = 1'b1;
             end
      READ:  if (rd_load && last_beat) state_d = DRAIN;
      DRAIN: if (rd_pop) begin
               state_d = IDLE;
               done_d  = 1'b1;
             end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Address wraps naturally at 2^ADDR_WIDTH.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      addr_q  <= '0;
      beats_q <= '0;
    end else if (accept) begin
      addr_q  <= bus.req_addr_i;
      beats_q <= bus.req_len_i;
    end else if (wr_beat || rd_load) begin
      addr_q  <= addr_q + 1'b1;
      beats_q <= beats_q - 1'b1;
    end
  end

  rd_out_reg #(
    .WIDTH (ELEM_WIDTH)
  ) u_rd_out_reg (
    .clk_i   (clk_i),
    .srst_i  (srst_i),
    .load_i  (rd_load),
    .data_i  (bus.mem_rdata_i),
    .ready_i (bus.rd_ready_i),
    .valid_o (rd_valid),
    .data_o  (rd_data)
  );

  // Outputs are forced to their idle values for the whole reset cycle, not
  // only after the first reset edge.
  assign bus.req_ready_o = (state_q == IDLE) && !srst_i;
  assign bus.busy_o      = (state_q != IDLE) && !srst_i;
  assign bus.done_o      = done_q && !srst_i;
  assign bus.wr_ready_o  = (state_q == WRITE) && !srst_i;
  assign bus.mem_we_o    = bus.wr_ready_o && bus.wr_valid_i;
  assign bus.mem_wdata_o = bus.wr_ready_o ? bus.wr_data_i : '0;
  assign bus.mem_addr_o  = srst_i ? '0 : addr_q;
  assign bus.rd_valid_o  = rd_valid && !srst_i;
  assign bus.rd_data_o   = srst_i ? '0 : rd_data;

endmodule
